// File: rtl/scu_pkg.sv
// scu_pkg: FSM state encoding and grant codes shared by scu and the interconnect muxes
package scu_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, GNT_M1 = 2'b01, GNT_M2 = 2'b10} scu_state_e;
  localparam logic [1:0] MAS_NONE = 2'b00;
  localparam logic [1:0] MAS_M1 = 2'b01;
  localparam logic [1:0] MAS_M2 = 2'b10;
endpackage

// File: rtl/scu.sv
// scu: two-master bus arbiter (clk, rstn sync active-high reset, sel_m1/sel_m2 requests, endtrans ends ownership, mas_sel registered grant)
module scu
  import scu_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       sel_m1,
  input  logic       sel_m2,
  input  logic       endtrans,
  output logic [1:0] mas_sel
);
  scu_state_e state, state_nx;
  logic last_m2, last_nx;
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE:           state_nx = (sel_m1 && (!sel_m2 || last_m2)) ? GNT_M1 : sel_m2 ? GNT_M2 : IDLE;
      GNT_M1, GNT_M2: state_nx = endtrans ? IDLE : state;
      default:        state_nx = IDLE;
    endcase
    last_nx = (state == IDLE && state_nx != IDLE) ? (state_nx == GNT_M2) : last_m2;
  end
  always_ff @(posedge clk)
    if (rstn) begin
      state   <= IDLE;
      last_m2 <= 1'b1;
    end else begin
      state   <= state_nx;
      last_m2 <= last_nx;
    end
  assign mas_sel = state;
endmodule

// File: tb/tb_scu.sv
// tb_scu: directed vector table plus randomized soak against an owner/last-served model
module tb_scu;
  logic clk = 1'b0;
  logic rstn, sel_m1, sel_m2, endtrans;
  logic [1:0] mas_sel;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic r, a, b, e;
    logic [1:0] x;
  } vec_t;
  vec_t tv[$];
  scu dut (.clk(clk), .rstn(rstn), .sel_m1(sel_m1), .sel_m2(sel_m2), .endtrans(endtrans), .mas_sel(mas_sel));
  always #5 clk = ~clk;
  function automatic vec_t v(logic r, logic a, logic b, logic e, logic [1:0] x);
    vec_t t;
    t.r = r; t.a = a; t.b = b; t.e = e; t.x = x;
    return t;
  endfunction
  task automatic step(logic r, logic a, logic b, logic e);
    rstn = r; sel_m1 = a; sel_m2 = b; endtrans = e;
    @(posedge clk);
    #1;
  endtask
  task automatic check(string name, logic [1:0] act, logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: mas_sel=%b expected %b", name, act, exp);
    end
  endtask
  initial begin
    int owner, last, prev;
    logic r, a, b, e;
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    tv.push_back(v(1'b0, 1'b1, 1'b0, 1'b0, 2'b01));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b0, 2'b01));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
    tv.push_back(v(1'b1, 1'b1, 1'b1, 1'b0, 2'b00));
    tv.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 2'b01));
    tv.push_back(v(1'b0, 1'b1, 1'b1, 1'b1, 2'b00));
    tv.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 2'b10));
    tv.push_back(v(1'b0, 1'b1, 1'b1, 1'b1, 2'b00));
    tv.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 2'b01));
    tv.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 2'b01));
    tv.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 2'b01));
    tv.push_back(v(1'b0, 1'b0, 1'b1, 1'b1, 2'b00));
    tv.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 2'b10));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
    tv.push_back(v(1'b0, 1'b0, 1'b1, 1'b0, 2'b10));
    tv.push_back(v(1'b1, 1'b1, 1'b1, 1'b0, 2'b00));
    tv.push_back(v(1'b0, 1'b1, 1'b1, 1'b0, 2'b01));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
    tv.push_back(v(1'b0, 1'b1, 1'b0, 1'b1, 2'b01));
    tv.push_back(v(1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
      check($sformatf("reset%0d", i), mas_sel, 2'b00);
    end
    foreach (tv[i]) begin
      step(tv[i].r, tv[i].a, tv[i].b, tv[i].e);
      check($sformatf("vec%0d", i), mas_sel, tv[i].x);
    end
    owner = 0; last = 2; prev = 0;
    for (int i = 0; i < 100; i++) begin
      r = (i == 0) || ($urandom_range(0, 19) == 0);
      a = 1'($urandom); b = 1'($urandom); e = 1'($urandom);
      step(r, a, b, e);
      if (r) begin
        owner = 0; last = 2;
      end else if (owner == 0) begin
        if (a && b) owner = (last == 2) ? 1 : 2;
        else if (a) owner = 1;
        else if (b) owner = 2;
        if (owner != 0) last = owner;
      end else if (e) owner = 0;
      check($sformatf("soak%0d", i), mas_sel, 2'(owner));
      checks++;
      if (mas_sel == 2'b11) begin
        errors++;
        $display("FAIL soak_illegal%0d: mas_sel=%b expected not 11", i, mas_sel);
      end
      checks++;
      if (prev != 0 && mas_sel != 2'b00 && int'(mas_sel) != prev) begin
        errors++;
        $display("FAIL soak_handoff%0d: mas_sel=%b after %0d expected 00 between owners", i, mas_sel, prev);
      end
      prev = int'(mas_sel);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scu.md
# scu

Selection control unit for the two-master AXI interconnect. It arbitrates bus ownership between master 1 and master 2 using their request lines. It holds the grant until the owning master signals end of transaction. The registered `mas_sel` output drives the interconnect's master-side multiplexers.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock; the only clock.
- `rstn` input 1: reset, synchronous, active-high (asserted = 1). The port name is kept for codebase compatibility.
- `sel_m1` input 1: master 1 requests the bus.
- `sel_m2` input 1: master 2 requests the bus.
- `endtrans` input 1: the current owner's transaction completes this cycle.
- `mas_sel` output 2: grant. 2'b00 = none, 2'b01 = master 1, 2'b10 = master 2. 2'b11 is never driven.

## Operation
- Moore FSM with a 2-bit `state` register (visible hierarchically by that name):
  - IDLE = 2'b00
  - GNT_M1 = 2'b01
  - GNT_M2 = 2'b10
- `mas_sel` = `state` (direct register output, no combinational path from inputs).
- One-bit `last_m2` register records the most recently granted master; it is used for tie-breaking.
- IDLE transitions:
  - only `sel_m1` → GNT_M1
  - only `sel_m2` → GNT_M2
  - both asserted → grant the master not served last: `last_m2`=1 → GNT_M1, `last_m2`=0 → GNT_M2
  - neither → stay IDLE
  - `endtrans` is ignored in IDLE.
- GNT_M1 / GNT_M2:
  - hold regardless of the `sel_*` values, including if the owner deasserts its request
  - `endtrans`=1 → IDLE.
  - No direct owner-to-owner handoff; at least one IDLE cycle always separates grants.
- `last_m2` updates on entry to a grant state: 1 for GNT_M2, 0 for GNT_M1.
- Illegal `state` 2'b11 → IDLE on the next clock.
- Reset, including mid-grant: `state` = IDLE, `mas_sel` = 2'b00, `last_m2` = 1, so master 1 wins the first tie.

## Timing
- Inputs are sampled on the rising edge. `mas_sel` changes one clock after the qualifying input edge.
- Request to grant: 1 cycle from IDLE.
- `endtrans` to `mas_sel`=00: 1 cycle.
- Minimum grant length is 1 cycle: `endtrans` may already be high on the first cycle of a grant.
- Back-to-back rearbitration: a request pending during `endtrans` is granted 2 cycles after the `endtrans` edge.
- `rstn` overrides all inputs on the same edge.
- Inputs are synchronous to `clk`; no internal synchronizers.

## Structure
- Package `scu_pkg`:
  - `typedef enum logic [1:0] {IDLE=2'b00, GNT_M1=2'b01, GNT_M2=2'b10} scu_state_e`
  - localparams `MAS_NONE`, `MAS_M1`, `MAS_M2`, shared with the interconnect muxes.
- Single flat module: next-state `always_comb` plus one `always_ff` for `state` and `last_m2`.
- No sub-module. The tie-break is a single bit and does not justify one.

## Test plan
- Reset: `rstn`=1 for 2 cycles with random inputs → `mas_sel`=00 throughout; release with all inputs 0 → remains 00.
- Single request: `sel_m1`=1 → `mas_sel`=01 after 1 clk; drop `sel_m1` with `endtrans`=0 → stays 01; pulse `endtrans` → 00 after 1 clk.
- Tie-break fairness:
  - `sel_m1`=`sel_m2`=1 after reset → 01; `endtrans` → 00.
  - Both still requesting → 10; `endtrans` → 00.
  - Then 01 again; grants alternate.
- Ignored inputs: `endtrans`=1 while IDLE with no requests → 00. `sel_m2`=1 during GNT_M1 → 01 held until `endtrans`.
- Reset mid-grant: in GNT_M2, assert `rstn` → 00 next clk. After release with both requesting → 01, because `last_m2` resets to 1.
- Random soak: 100 cycles of random `{sel_m1,sel_m2,endtrans}` checked against a reference model:
  - `mas_sel` never 11
  - no 01↔10 transition without an intervening 00.
